// File: rtl/softmax_pkg.sv
// Shared defaults and FSM encoding for the softmax max-finder (pass 1).
package softmax_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int VEC_LEN_DEF    = 7;
    localparam int CNT_WIDTH_DEF  = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_DONE   = 3'd3,
        ST_REWIND = 3'd4
    } state_t;

endpackage

// File: rtl/softmax_max_acc.sv
// Running max / argmax accumulator. A one-cycle delayed read enable marks
// fifo data as valid; the first valid sample of a vector loads unconditionally,
// later ones replace the maximum only when strictly greater (earliest index wins ties).
module softmax_max_acc
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  cap_vld,
    output logic [DATA_WIDTH-1:0] max_val,
    output logic [CNT_WIDTH-1:0]  max_idx
);

    function automatic logic is_greater(input logic signed [DATA_WIDTH-1:0] a,
                                        input logic signed [DATA_WIDTH-1:0] b);
        return (a > b);
    endfunction

    logic                         vld_p1;
    logic                         have_max;
    logic        [CNT_WIDTH-1:0]  cap_cnt;
    logic signed [DATA_WIDTH-1:0] sample_p1;
    logic signed [DATA_WIDTH-1:0] max_q;
    logic        [CNT_WIDTH-1:0]  idx_q;
    logic                         take;

    assign sample_p1 = $signed(data);
    assign take      = vld_p1 && !init && (!have_max || is_greater(sample_p1, max_q));

    assign cap_vld = vld_p1;
    assign max_val = max_q;
    assign max_idx = idx_q;

    // Stage p1: delayed read enable qualifies fifo data; update count, first flag and max/idx
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            have_max <= 1'b0;
            cap_cnt  <= '0;
            max_q    <= '0;
            idx_q    <= '0;
        end else begin
            vld_p1 <= rd_en;
            if (init) begin
                have_max <= 1'b0;
                cap_cnt  <= '0;
            end else if (vld_p1) begin
                have_max <= 1'b1;
                cap_cnt  <= cap_cnt + 1'b1;
            end
            if (take) begin
                max_q <= sample_p1;
                idx_q <= cap_cnt;
            end
        end
    end

endmodule

// File: rtl/softmax_max_finder.sv
// Softmax pass 1: reads one vector from the FIFO, reports max/argmax over a
// valid/ready handshake, then pulses the FIFO read-pointer clear so the next
// stage can re-read the same vector. All outputs are registered.
module softmax_max_finder
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int VEC_LEN    = VEC_LEN_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  fifo_rd_en,
    output logic                  fifo_rd_inc,
    output logic                  fifo_rd_clr,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic [DATA_WIDTH-1:0] max_out,
    output logic [CNT_WIDTH-1:0]  max_idx,
    output logic                  max_valid,
    input  logic                  max_ready
);

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(VEC_LEN - 1);

    state_t                  state;
    state_t                  next_state;
    logic [CNT_WIDTH-1:0]    rd_cnt;
    logic                    init;
    logic                    acc_vld;
    logic [DATA_WIDTH-1:0]   acc_max;
    logic [CNT_WIDTH-1:0]    acc_idx;

    // A new vector begins only when start is seen in IDLE; anything else ignores start.
    assign init = (state == ST_IDLE) && start;

    // The read-pointer increment is the same flop as the read enable.
    assign fifo_rd_inc = fifo_rd_en;

    softmax_max_acc #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .init    (init),
        .rd_en   (fifo_rd_en),
        .data    (fifo_data),
        .cap_vld (acc_vld),
        .max_val (acc_max),
        .max_idx (acc_idx)
    );

    // Next-state logic; DRAIN waits until the last in-flight sample has been captured.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start)                   next_state = ST_READ;
            ST_READ:   if (rd_cnt == LAST_IDX)      next_state = ST_DRAIN;
            ST_DRAIN:  if (!acc_vld)                next_state = ST_DONE;
            ST_DONE:   if (max_valid && max_ready)  next_state = ST_REWIND;
            ST_REWIND:                              next_state = ST_IDLE;
            default:                                next_state = ST_IDLE;
        endcase
    end

    // State register and read issue counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rd_cnt <= '0;
        end else begin
            state <= next_state;
            if (init) begin
                rd_cnt <= '0;
            end else if ((state == ST_READ) && (rd_cnt != LAST_IDX)) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Output flops decoded from the next state so every output is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            fifo_rd_en  <= 1'b0;
            fifo_rd_clr <= 1'b0;
            max_valid   <= 1'b0;
            max_out     <= '0;
            max_idx     <= '0;
        end else begin
            busy        <= (next_state != ST_IDLE);
            fifo_rd_en  <= (next_state == ST_READ);
            fifo_rd_clr <= (next_state == ST_REWIND);
            max_valid   <= (next_state == ST_DONE);
            if ((state != ST_DONE) && (next_state == ST_DONE)) begin
                max_out <= acc_max;
                max_idx <= acc_idx;
            end
        end
    end

endmodule
